// File: rtl/fifo_pkg.sv
// Shared types and constants for the 8-bit FIFO and its request agents.
package fifo_pkg;

    localparam int FIFO_DW    = 8;
    localparam int FIFO_DEPTH = 10;
    localparam int STAT_W     = 16;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } fifo_op_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        BACKOFF,
        RESP
    } req_state_e;

endpackage

// File: rtl/fifo_req_stats.sv
// Saturating event counters for fifo_requester (used when FIFO_REQUESTER_STATS_EN is defined).
module fifo_req_stats
    import fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_ok,
    input  logic              inc_fail,
    input  logic              inc_retry,
    output logic [STAT_W-1:0] ok_cnt,
    output logic [STAT_W-1:0] fail_cnt,
    output logic [STAT_W-1:0] retry_cnt
);

    logic [STAT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [STAT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [STAT_W-1:0] retry_cnt_q, retry_cnt_d;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + STAT_W'(1) : v;
    endfunction

    always_comb begin
        ok_cnt_d    = sat_inc(ok_cnt_q, inc_ok);
        fail_cnt_d  = sat_inc(fail_cnt_q, inc_fail);
        retry_cnt_d = sat_inc(retry_cnt_q, inc_retry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_cnt_q    <= '0;
            fail_cnt_q  <= '0;
            retry_cnt_q <= '0;
        end else begin
            ok_cnt_q    <= ok_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    assign ok_cnt    = ok_cnt_q;
    assign fail_cnt  = fail_cnt_q;
    assign retry_cnt = retry_cnt_q;

endmodule

// File: rtl/fifo_requester.sv
// Master-side request agent for the shared FIFO: one command at a time, retry with back-off.
// Define FIFO_REQUESTER_STATS_EN to add the saturating stat_*_cnt outputs.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for an upstream command
// ISSUE   | single-cycle write_valid / read_valid pulse to the FIFO
// WAIT    | FIFO response flags sampled for the latched op
// BACKOFF | idle gap before re-issuing after a refusal
// RESP    | one-cycle rsp_valid with the final result
module fifo_requester
    import fifo_pkg::*;
#(
    parameter int MAX_RETRY = 3,
    parameter int BACKOFF   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [FIFO_DW-1:0] cmd_data,
    output logic               rsp_valid,
    output logic               rsp_ok,
    output logic [FIFO_DW-1:0] rsp_data,
    output logic [3:0]         rsp_retries,
    output logic               rsp_err,
    output logic               write_valid,
    output logic [FIFO_DW-1:0] write_data,
    output logic               read_valid,
    input  logic               write_full,
    input  logic               write_success,
    input  logic               read_empty,
    input  logic               read_success,
    input  logic [FIFO_DW-1:0] read_data
`ifdef FIFO_REQUESTER_STATS_EN
    ,
    output logic [15:0]        stat_ok_cnt,
    output logic [15:0]        stat_fail_cnt,
    output logic [15:0]        stat_retry_cnt
`endif
);

    // The BACKOFF parameter hides the package state literal of the same name.
    localparam req_state_e ST_BACKOFF = fifo_pkg::BACKOFF;
    localparam logic [3:0] MAX_R      = 4'(MAX_RETRY);
    localparam logic [3:0] BO_LOAD    = (BACKOFF > 0) ? 4'(BACKOFF - 1) : 4'd0;

    req_state_e         state_q, state_d;
    fifo_op_e           op_q, op_d;
    logic [FIFO_DW-1:0] data_q, data_d;
    logic [3:0]         retry_q, retry_d;
    logic [3:0]         bo_cnt_q, bo_cnt_d;

    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_ok_q, rsp_ok_d;
    logic [FIFO_DW-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]         rsp_retries_q, rsp_retries_d;
    logic               rsp_err_q, rsp_err_d;
    logic               write_valid_q, write_valid_d;
    logic [FIFO_DW-1:0] write_data_q, write_data_d;
    logic               read_valid_q, read_valid_d;

    logic               fifo_ack;
    logic               fifo_refuse;

    assign fifo_ack    = (op_q == OP_RD) ? read_success : write_success;
    assign fifo_refuse = (op_q == OP_RD) ? read_empty   : write_full;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        data_d        = data_q;
        retry_d       = retry_q;
        bo_cnt_d      = bo_cnt_q;
        rsp_ok_d      = rsp_ok_q;
        rsp_data_d    = rsp_data_q;
        rsp_retries_d = rsp_retries_q;
        rsp_err_d     = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = fifo_op_e'(cmd_op);
                    data_d  = cmd_data;
                    retry_d = 4'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                rsp_retries_d = retry_q;
                rsp_data_d    = '0;
                rsp_ok_d      = 1'b0;
                rsp_err_d     = 1'b0;
                if (fifo_ack && !fifo_refuse) begin
                    rsp_ok_d   = 1'b1;
                    rsp_data_d = (op_q == OP_RD) ? read_data : '0;
                    state_d    = RESP;
                end else if (fifo_refuse && !fifo_ack) begin
                    if (retry_q < MAX_R) begin
                        retry_d       = retry_q + 4'd1;
                        bo_cnt_d      = BO_LOAD;
                        state_d       = (BACKOFF > 0) ? ST_BACKOFF : ISSUE;
                        // Keep the previous response visible while retrying.
                        rsp_ok_d      = rsp_ok_q;
                        rsp_data_d    = rsp_data_q;
                        rsp_retries_d = rsp_retries_q;
                        rsp_err_d     = rsp_err_q;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end
            end
            ST_BACKOFF: begin
                if (bo_cnt_q == 4'd0) begin
                    state_d = ISSUE;
                end else begin
                    bo_cnt_d = bo_cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cmd_ready_d   = (state_d == IDLE);
        rsp_valid_d   = (state_d == RESP);
        write_valid_d = (state_d == ISSUE) && (op_d == OP_WR);
        read_valid_d  = (state_d == ISSUE) && (op_d == OP_RD);
        write_data_d  = write_valid_d ? data_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= OP_WR;
            data_q        <= '0;
            retry_q       <= 4'd0;
            bo_cnt_q      <= 4'd0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_ok_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_retries_q <= 4'd0;
            rsp_err_q     <= 1'b0;
            write_valid_q <= 1'b0;
            write_data_q  <= '0;
            read_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            data_q        <= data_d;
            retry_q       <= retry_d;
            bo_cnt_q      <= bo_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_ok_q      <= rsp_ok_d;
            rsp_data_q    <= rsp_data_d;
            rsp_retries_q <= rsp_retries_d;
            rsp_err_q     <= rsp_err_d;
            write_valid_q <= write_valid_d;
            write_data_q  <= write_data_d;
            read_valid_q  <= read_valid_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_ok      = rsp_ok_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_retries = rsp_retries_q;
    assign rsp_err     = rsp_err_q;
    assign write_valid = write_valid_q;
    assign write_data  = write_data_q;
    assign read_valid  = read_valid_q;

`ifdef FIFO_REQUESTER_STATS_EN
    logic ok_evt, fail_evt, retry_evt;

    // Events fire on the WAIT decision edge, alongside the response or re-issue.
    assign ok_evt    = (state_q == WAIT) && (state_d == RESP) && rsp_ok_d;
    assign fail_evt  = (state_q == WAIT) && (state_d == RESP) && !rsp_ok_d;
    assign retry_evt = (state_q == WAIT) && (state_d != RESP);

    fifo_req_stats u_stats (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_ok    (ok_evt),
        .inc_fail  (fail_evt),
        .inc_retry (retry_evt),
        .ok_cnt    (stat_ok_cnt),
        .fail_cnt  (stat_fail_cnt),
        .retry_cnt (stat_retry_cnt)
    );
`endif

endmodule

// File: tb/tb_fifo_requester.sv
// Scoreboard bench for fifo_requester against a 10-deep behavioural FIFO model.
module tb_fifo_requester;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid, cmd_ready, cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ok, rsp_err;
    logic [7:0] rsp_data;
    logic [3:0] rsp_retries;
    logic       write_valid, read_valid;
    logic [7:0] write_data;
    logic       write_full = 1'b0, write_success = 1'b0;
    logic       read_empty = 1'b0, read_success = 1'b0;
    logic [7:0] read_data = 8'h00;
`ifdef FIFO_REQUESTER_STATS_EN
    logic [15:0] stat_ok_cnt, stat_fail_cnt, stat_retry_cnt;
`endif

    always #5 clk = ~clk;

    fifo_requester #(.MAX_RETRY(3), .BACKOFF(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ok        (rsp_ok),
        .rsp_data      (rsp_data),
        .rsp_retries   (rsp_retries),
        .rsp_err       (rsp_err),
        .write_valid   (write_valid),
        .write_data    (write_data),
        .read_valid    (read_valid),
        .write_full    (write_full),
        .write_success (write_success),
        .read_empty    (read_empty),
        .read_success  (read_success),
        .read_data     (read_data)
`ifdef FIFO_REQUESTER_STATS_EN
        ,
        .stat_ok_cnt   (stat_ok_cnt),
        .stat_fail_cnt (stat_fail_cnt),
        .stat_retry_cnt(stat_retry_cnt)
`endif
    );

    typedef struct packed {
        logic       ok;
        logic [7:0] data;
        logic [3:0] retries;
        logic       err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rsp_n = 0, rsp_cyc = 0, wv_n = 0, rv_n = 0;
    int   wv_cyc[$];
    logic [7:0] last_wdata = 8'h00;
    int   tally_ok = 0, tally_fail = 0, tally_retry = 0;

    // FIFO model: request in cycle N, flags in cycle N+1
    logic       noflag = 1'b0;
    logic       inject_req = 1'b0;
    logic [7:0] inject_data = 8'h00;
    logic [7:0] fq[$];

    always @(posedge clk) begin
        write_full    <= 1'b0;
        write_success <= 1'b0;
        read_empty    <= 1'b0;
        read_success  <= 1'b0;
        if (inject_req) fq.push_back(inject_data);
        if (!noflag) begin
            if (write_valid) begin
                if (fq.size() < 10) begin
                    fq.push_back(write_data);
                    write_success <= 1'b1;
                end else begin
                    write_full <= 1'b1;
                end
            end
            if (read_valid) begin
                if (fq.size() > 0) begin
                    read_data    <= fq.pop_front();
                    read_success <= 1'b1;
                end else begin
                    read_empty <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: request tracking and scoreboard pop on every rsp_valid
    always @(posedge clk) begin
        #1;
        if (write_valid || read_valid) check("one_request", int'(write_valid && read_valid), 0);
        if (write_valid) begin
            wv_n++;
            wv_cyc.push_back(cyc);
            last_wdata = write_data;
        end
        if (read_valid) rv_n++;
        if (rsp_valid) begin
            rsp_n++;
            rsp_cyc = cyc;
            check("rsp_cmd_ready_low", int'(cmd_ready), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid expected none");
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_ok", int'(rsp_ok), int'(mon_e.ok));
                check("rsp_data", int'(rsp_data), int'(mon_e.data));
                check("rsp_retries", int'(rsp_retries), int'(mon_e.retries));
                check("rsp_err", int'(rsp_err), int'(mon_e.err));
            end
        end
    end

    task automatic expect_rsp(input logic ok, input logic [7:0] d, input logic [3:0] r, input logic e);
        rsp_t x;
        x = '{ok: ok, data: d, retries: r, err: e};
        exp_q.push_back(x);
        if (ok) tally_ok++;
        else tally_fail++;
        tally_retry += int'(r);
    endtask

    task automatic send(input logic op, input logic [7:0] d, output int t);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: got cmd_ready 0 expected 1 within 100 cycles");
        end
        t = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n_before);
        int k;
        k = 0;
        while (rsp_n == n_before && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (rsp_n == n_before) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 200 cycles");
        end
    endtask

    task automatic do_cmd(input logic op, input logic [7:0] d, input logic ok,
                          input logic [7:0] rd, input logic [3:0] r, input logic e, output int t);
        int n;
        n = rsp_n;
        expect_rsp(ok, rd, r, e);
        send(op, d, t);
        wait_rsp(n);
    endtask

    task automatic wait_rv(input int target);
        int k;
        k = 0;
        while (rv_n < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (rv_n < target) begin
            checks++;
            errors++;
            $display("FAIL rv_timeout: got %0d read pulses expected %0d", rv_n, target);
        end
    endtask

`ifdef FIFO_REQUESTER_STATS_EN
    task automatic check_stats(input string tag);
        check({tag, "_stat_ok"}, int'(stat_ok_cnt), tally_ok);
        check({tag, "_stat_fail"}, int'(stat_fail_cnt), tally_fail);
        check({tag, "_stat_retry"}, int'(stat_retry_cnt), tally_retry);
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n, wv0, rv0;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_data  = 8'h00;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_write_valid", int'(write_valid), 0);
        check("rst_read_valid", int'(read_valid), 0);
        check("rst_rsp_fields", int'({rsp_ok, rsp_err, rsp_retries, rsp_data}), 0);
        check("rst_write_data", int'(write_data), 0);
        rst_n = 1'b1;

        // Single write: pulse at T+1, response at T+3
        wv0 = wv_n;
        wv_cyc.delete();
        do_cmd(1'b0, 8'hA5, 1'b1, 8'h00, 4'd0, 1'b0, t);
        check("wr_pulse_count", wv_n - wv0, 1);
        check("wr_pulse_cycle", wv_cyc.size() > 0 ? wv_cyc[0] : -1, t + 1);
        check("wr_data_on_bus", int'(last_wdata), 8'hA5);
        check("wr_rsp_cycle", rsp_cyc, t + 3);
        @(negedge clk);
        check("ready_after_rsp", int'(cmd_ready), 1);

        do_cmd(1'b1, 8'h00, 1'b1, 8'hA5, 4'd0, 1'b0, t);
        check("rd_rsp_cycle", rsp_cyc, t + 3);

        for (int i = 1; i <= 10; i++) do_cmd(1'b0, 8'(i), 1'b1, 8'h00, 4'd0, 1'b0, t);

        // Full FIFO: 4 requests spaced 2+BACKOFF, then failure
        wv0 = wv_n;
        wv_cyc.delete();
        do_cmd(1'b0, 8'hFF, 1'b0, 8'h00, 4'd3, 1'b0, t);
        check("full_pulse_count", wv_n - wv0, 4);
        for (int i = 1; i < wv_cyc.size(); i++) check("full_pulse_spacing", wv_cyc[i] - wv_cyc[i-1], 4);
        check("full_rsp_cycle", rsp_cyc, t + 15);

        do_cmd(1'b1, 8'h00, 1'b1, 8'h01, 4'd0, 1'b0, t);
        do_cmd(1'b1, 8'h00, 1'b1, 8'h02, 4'd0, 1'b0, t);
        for (int i = 3; i <= 10; i++) do_cmd(1'b1, 8'h00, 1'b1, 8'(i), 4'd0, 1'b0, t);

        // Empty read; data lands during the second back-off
        n   = rsp_n;
        rv0 = rv_n;
        expect_rsp(1'b1, 8'h3C, 4'd2, 1'b0);
        send(1'b1, 8'h00, t);
        wait_rv(rv0 + 2);
        repeat (2) @(negedge clk);
        inject_data = 8'h3C;
        inject_req  = 1'b1;
        @(negedge clk);
        inject_req  = 1'b0;
        wait_rsp(n);
        check("empty_rd_pulses", rv_n - rv0, 3);
        check("empty_rd_rsp_cycle", rsp_cyc, t + 11);

        // FIFO silent in WAIT -> protocol error, no retry
        noflag = 1'b1;
        wv0 = wv_n;
        do_cmd(1'b0, 8'h77, 1'b0, 8'h00, 4'd0, 1'b1, t);
        noflag = 1'b0;
        check("noflag_pulses", wv_n - wv0, 1);
        check("noflag_rsp_cycle", rsp_cyc, t + 3);

`ifdef FIFO_REQUESTER_STATS_EN
        check_stats("pre_rst");
`endif

        // Reset during BACKOFF abandons the read silently
        n   = rsp_n;
        rv0 = rv_n;
        send(1'b1, 8'h00, t);
        wait_rv(rv0 + 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        tally_ok = 0;
        tally_fail = 0;
        tally_retry = 0;
        @(negedge clk);
        check("mid_rst_cmd_ready", int'(cmd_ready), 1);
        check("mid_rst_rsp_err", int'(rsp_err), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abandon_no_rsp", rsp_n, n);
        check("abandon_no_reissue", rv_n - rv0, 1);
        check("post_rst_cmd_ready", int'(cmd_ready), 1);
        check("scoreboard_drained", exp_q.size(), 0);

        do_cmd(1'b0, 8'h5A, 1'b1, 8'h00, 4'd0, 1'b0, t);
        check("post_rst_rsp_cycle", rsp_cyc, t + 3);
`ifdef FIFO_REQUESTER_STATS_EN
        check_stats("post_rst");
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
